ptw_resp_tlb: RTL and testbench
===============================

Name: ptw_resp_tlb

Overview:
- Parametrised successor to the fixed two-entry PTW response tag store.
- Fully associative N-entry translation cache between a requester (I- or D-side) and the page-table walker.
- Hits answer in one cycle; misses issue a walker request, wait for the response, fill an entry and answer.
- Adds tag match, error caching policy, replacement, flush and valid/ready handshakes.

Parameters:
ENTRIES, 8, number of entries (power of two, >=2)
VPN_W, 20, virtual page number width
PPN_W, 32, physical page number width

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
req_valid  input  1  lookup request valid
req_ready  output  1  high only in IDLE
req_vpn  input  VPN_W  lookup VPN
resp_valid  output  1  one-cycle response pulse, no back-pressure
resp_hit  output  1  1 = served from cache, 0 = served by walker
resp_error  output  1  walker reported fault
resp_ppn  output  PPN_W  translated PPN, 0 when resp_error=1
ptw_req_valid  output  1  walker request valid
ptw_req_ready  input  1  walker accepts request
ptw_req_vpn  output  VPN_W  VPN sent to walker
ptw_resp_valid  input  1  walker response valid
ptw_resp_error  input  1  walker fault
ptw_resp_ppn  input  PPN_W  walker PPN
flush  input  1  invalidate all entries

Behaviour:
- Reset: state IDLE; all valid bits 0; replacement pointer 0; all outputs 0 except req_ready=1. Reset in any state aborts the transaction; no response is produced.
- Storage per entry: valid, vpn tag, ppn. Errors are never cached.
- Handshake: a request is accepted when req_valid & req_ready. The VPN is captured into a lookup register.
- State LOOKUP, one cycle after accept:
  - Compare against all valid tags. Multiple matches cannot occur; if forced, lowest index wins.
  - Hit: resp_valid=1, resp_hit=1, resp_ppn=entry ppn; next state IDLE. Latency is 1 cycle from accept.
  - Miss: next state PTW_REQ.
- State PTW_REQ:
  - Drive ptw_req_valid=1 with ptw_req_vpn = captured VPN, held stable until ptw_req_ready.
  - On ptw_req_valid & ptw_req_ready: next state PTW_WAIT.
- State PTW_WAIT:
  - Ignore all cycles until ptw_resp_valid.
  - On ptw_resp_valid: resp_valid=1, resp_hit=0, resp_error=ptw_resp_error, resp_ppn = error ? 0 : ptw_resp_ppn; next state IDLE.
  - If no error and no flush is pending, fill the victim in the same edge.
- Victim selection: lowest-index invalid entry. If none is invalid, use the replacement pointer, then advance it (ENTRIES-1 wraps to 0). The pointer advances only on a pointer-chosen fill.
- ptw_resp_valid outside PTW_WAIT: ignored.
- Flush:
  - Any cycle: all valid bits are 0 from the next cycle; the pointer resets to 0.
  - Flush in LOOKUP: lookup completes against pre-flush contents.
  - Flush asserted in PTW_REQ or PTW_WAIT sets a pending flag. The later fill is suppressed but the response is still delivered; the flag clears on return to IDLE.
  - Flush coincident with a fill edge: flush wins, the entry is not written.
- Outputs not listed for a state are 0; resp_* are 0 whenever resp_valid=0.
- A back-to-back request may be accepted the cycle after resp_valid (IDLE).

Test Plan:
- Reset, then req vpn=0x00012 -> miss, ptw_req_vpn=0x00012. Walker replies ppn=0xABCD0000 err=0 -> resp_valid, hit=0, ppn=0xABCD0000. Re-request 0x00012 -> resp one cycle after accept, hit=1, ppn=0xABCD0000.
- Fill 8 distinct VPNs 0x1..0x8 (fill entries 0..7), then miss 0x9 -> replaces entry 0 (pointer 0->1). Lookup 0x1 misses; lookup 0x2 hits.
- Walker reply err=1, ppn=0x5555 for vpn 0x20 -> resp_error=1, ppn=0. Repeat 0x20 -> misses again (not cached).
- Hold ptw_req_ready=0 for 5 cycles -> ptw_req_valid and ptw_req_vpn stay stable, no response. Ready=1 -> PTW_WAIT.
- Flush during PTW_WAIT, reply ppn=0x77 -> response delivered with hit=0. Re-request -> miss; earlier-cached VPN also misses.
- Reset asserted in PTW_WAIT, then ptw_resp_valid pulse -> no resp_valid, req_ready=1, next lookup of the prior VPN misses.

Source files
------------

// File: rtl/ptw_resp_tlb_if.sv
// Requester and page-table-walker signal bundle for ptw_resp_tlb.
// The slave modport is the TLB; master is whatever drives requests and walker replies.
interface ptw_resp_tlb_if #(
    parameter int VPN_W = 20,
    parameter int PPN_W = 32
);
    logic             req_valid;
    logic             req_ready;
    logic [VPN_W-1:0] req_vpn;
    logic             resp_valid;
    logic             resp_hit;
    logic             resp_error;
    logic [PPN_W-1:0] resp_ppn;
    logic             ptw_req_valid;
    logic             ptw_req_ready;
    logic [VPN_W-1:0] ptw_req_vpn;
    logic             ptw_resp_valid;
    logic             ptw_resp_error;
    logic [PPN_W-1:0] ptw_resp_ppn;
    logic             flush;

    modport master (
        output req_valid, req_vpn, flush, ptw_req_ready,
               ptw_resp_valid, ptw_resp_error, ptw_resp_ppn,
        input  req_ready, resp_valid, resp_hit, resp_error, resp_ppn,
               ptw_req_valid, ptw_req_vpn
    );

    modport slave (
        input  req_valid, req_vpn, flush, ptw_req_ready,
               ptw_resp_valid, ptw_resp_error, ptw_resp_ppn,
        output req_ready, resp_valid, resp_hit, resp_error, resp_ppn,
               ptw_req_valid, ptw_req_vpn
    );
endinterface

// File: rtl/ptw_resp_tlb.sv
// Fully associative N-entry translation cache in front of the page-table walker.
// Hits answer in the LOOKUP cycle; misses fetch from the walker and fill a victim entry.
module ptw_resp_tlb #(
    parameter int ENTRIES = 8,
    parameter int VPN_W   = 20,
    parameter int PPN_W   = 32
) (
    input  logic           clk,
    input  logic           reset,
    ptw_resp_tlb_if.slave  bus
);
    localparam int IDX_W = $clog2(ENTRIES);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_LOOKUP   = 2'd1,
        ST_PTW_REQ  = 2'd2,
        ST_PTW_WAIT = 2'd3
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [VPN_W-1:0]   vpn_r;
    logic [ENTRIES-1:0] valid_r;
    logic [VPN_W-1:0]   tag_r [ENTRIES];
    logic [PPN_W-1:0]   ppn_r [ENTRIES];
    logic [IDX_W-1:0]   ptr_r;
    logic               flush_pend_r;

    logic [ENTRIES-1:0] match_s;
    logic               hit_s;
    logic [PPN_W-1:0]   hit_ppn_s;
    logic               has_inv_s;
    logic [IDX_W-1:0]   inv_idx_s;
    logic [IDX_W-1:0]   victim_idx_s;
    logic               accept_s;
    logic               fill_s;

    // Tag compare; scanning downwards lets the lowest matching index win
    always_comb begin
        hit_ppn_s = {PPN_W{1'b0}};
        for (int i = 0; i < ENTRIES; i++) begin
            match_s[i] = valid_r[i] & (tag_r[i] == vpn_r);
        end
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            hit_ppn_s = match_s[i] ? ppn_r[i] : hit_ppn_s;
        end
        hit_s = |match_s;
    end

    // Victim choice: lowest invalid entry, otherwise the round-robin pointer
    always_comb begin
        inv_idx_s = {IDX_W{1'b0}};
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            inv_idx_s = valid_r[i] ? inv_idx_s : IDX_W'(i);
        end
        has_inv_s    = ~&valid_r;
        victim_idx_s = has_inv_s ? inv_idx_s : ptr_r;
    end

    // Handshake qualifiers; a flush on the fill edge or an earlier pending flush blocks the write
    always_comb begin
        accept_s = bus.req_valid & (state_r == ST_IDLE);
        fill_s   = (state_r == ST_PTW_WAIT) & bus.ptw_resp_valid & ~bus.ptw_resp_error
                   & ~flush_pend_r & ~bus.flush;
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE:     state_nxt_s = bus.req_valid      ? ST_LOOKUP   : ST_IDLE;
            ST_LOOKUP:   state_nxt_s = hit_s              ? ST_IDLE     : ST_PTW_REQ;
            ST_PTW_REQ:  state_nxt_s = bus.ptw_req_ready  ? ST_PTW_WAIT : ST_PTW_REQ;
            ST_PTW_WAIT: state_nxt_s = bus.ptw_resp_valid ? ST_IDLE     : ST_PTW_WAIT;
            default:     state_nxt_s = ST_IDLE;
        endcase
    end

    // Output decode; every response field is zero unless resp_valid is high
    always_comb begin
        bus.req_ready     = 1'b0;
        bus.resp_valid    = 1'b0;
        bus.resp_hit      = 1'b0;
        bus.resp_error    = 1'b0;
        bus.resp_ppn      = {PPN_W{1'b0}};
        bus.ptw_req_valid = 1'b0;
        bus.ptw_req_vpn   = {VPN_W{1'b0}};
        case (state_r)
            ST_IDLE: begin
                bus.req_ready = 1'b1;
            end
            ST_LOOKUP: begin
                bus.resp_valid = hit_s;
                bus.resp_hit   = hit_s;
                bus.resp_ppn   = hit_s ? hit_ppn_s : {PPN_W{1'b0}};
            end
            ST_PTW_REQ: begin
                bus.ptw_req_valid = 1'b1;
                bus.ptw_req_vpn   = vpn_r;
            end
            ST_PTW_WAIT: begin
                bus.resp_valid = bus.ptw_resp_valid;
                bus.resp_error = bus.ptw_resp_valid & bus.ptw_resp_error;
                if (bus.ptw_resp_valid && !bus.ptw_resp_error) begin
                    bus.resp_ppn = bus.ptw_resp_ppn;
                end else begin
                    bus.resp_ppn = {PPN_W{1'b0}};
                end
            end
            default: begin
                bus.req_ready = 1'b0;
            end
        endcase
    end

    // Lookup VPN captured on accept and held for the whole transaction
    always_ff @(posedge clk) begin
        if (reset) begin
            vpn_r <= {VPN_W{1'b0}};
        end else if (accept_s) begin
            vpn_r <= bus.req_vpn;
        end else begin
            vpn_r <= vpn_r;
        end
    end

    // Pending flush remembers a flush seen while the walker owns the transaction
    always_ff @(posedge clk) begin
        if (reset) begin
            flush_pend_r <= 1'b0;
        end else if (state_r == ST_IDLE) begin
            flush_pend_r <= 1'b0;
        end else if (bus.flush && (state_r == ST_PTW_REQ || state_r == ST_PTW_WAIT)) begin
            flush_pend_r <= 1'b1;
        end else begin
            flush_pend_r <= flush_pend_r;
        end
    end

    // Valid bits and replacement pointer; flush beats a coincident fill
    always_ff @(posedge clk) begin
        if (reset || bus.flush) begin
            valid_r <= {ENTRIES{1'b0}};
            ptr_r   <= {IDX_W{1'b0}};
        end else if (fill_s) begin
            valid_r[victim_idx_s] <= 1'b1;
            ptr_r <= has_inv_s ? ptr_r : ptr_r + IDX_W'(1);
        end else begin
            valid_r <= valid_r;
            ptr_r   <= ptr_r;
        end
    end

    // Entry payload; contents are only meaningful behind a set valid bit
    always_ff @(posedge clk) begin
        if (fill_s) begin
            tag_r[victim_idx_s] <= vpn_r;
            ppn_r[victim_idx_s] <= bus.ptw_resp_ppn;
        end
    end
endmodule

// File: tb/tb_ptw_resp_tlb.sv
// Randomised and directed bench for ptw_resp_tlb against an array-based cache model.
module tb_ptw_resp_tlb;
    localparam int N = 8;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_fail;

    ptw_resp_tlb_if #(.VPN_W(20), .PPN_W(32)) bus ();

    ptw_resp_tlb #(.ENTRIES(N), .VPN_W(20), .PPN_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference cache: plain arrays, first-invalid-else-round-robin fill, errors never stored
    bit          m_valid [N];
    logic [19:0] m_vpn   [N];
    logic [31:0] m_ppn   [N];
    int          m_ptr;

    function automatic int model_find(input logic [19:0] v);
        for (int i = 0; i < N; i++) if (m_valid[i] && m_vpn[i] == v) return i;
        return -1;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
        m_ptr = 0;
    endtask

    task automatic model_fill(input logic [19:0] v, input logic [31:0] p);
        int slot;
        slot = -1;
        for (int i = 0; i < N; i++) if (!m_valid[i] && slot < 0) slot = i;
        if (slot < 0) begin
            slot  = m_ptr;
            m_ptr = (m_ptr + 1) % N;
        end
        m_valid[slot] = 1'b1;
        m_vpn[slot]   = v;
        m_ppn[slot]   = p;
    endtask

    task automatic do_reset();
        bus.req_valid = 1'b0; bus.req_vpn = 20'h0; bus.flush = 1'b0;
        bus.ptw_req_ready = 1'b0; bus.ptw_resp_valid = 1'b0;
        bus.ptw_resp_error = 1'b0; bus.ptw_resp_ppn = 32'h0;
        reset = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        model_clear();
    endtask

    // One full transaction; reports what the DUT did, never judges it
    task automatic run_req(input logic [19:0] vpn, input logic [31:0] rppn, input logic rerr,
                           input int rdy_dly, input int rsp_dly, input int flush_at,
                           output logic o_hit, output logic o_err, output logic [31:0] o_ppn,
                           output int o_lat, output int o_preq, output logic o_vok,
                           output logic o_tmo);
        int   cyc, widx;
        logic hs, done;
        o_hit = 1'b0; o_err = 1'b0; o_ppn = 32'h0; o_lat = 0; o_preq = 0;
        o_vok = 1'b1; o_tmo = 1'b0;
        hs = 1'b0; done = 1'b0; cyc = 0; widx = -1;
        bus.ptw_resp_ppn = rppn; bus.ptw_resp_error = rerr; bus.ptw_resp_valid = 1'b0;
        bus.ptw_req_ready = (rdy_dly == 0);
        bus.req_vpn = vpn; bus.req_valid = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        while (!done && cyc < 200) begin
            cyc++;
            @(negedge clk);
            if (bus.resp_valid) begin
                o_hit = bus.resp_hit; o_err = bus.resp_error; o_ppn = bus.resp_ppn;
                o_lat = cyc; done = 1'b1;
            end else if (bus.ptw_req_valid) begin
                o_preq++;
                if (bus.ptw_req_vpn !== vpn) o_vok = 1'b0;
                if (bus.ptw_req_ready) hs = 1'b1;
            end
            @(posedge clk); #1;
            if (hs) widx++;
            bus.ptw_req_ready  = !hs && (o_preq >= rdy_dly);
            bus.ptw_resp_valid = hs && !done && (widx == rsp_dly);
            bus.flush          = hs && !done && (widx == flush_at);
        end
        bus.ptw_resp_valid = 1'b0; bus.flush = 1'b0; bus.ptw_req_ready = 1'b0;
        o_tmo = !done;
    endtask

    logic        h, e, vok, tmo;
    logic [31:0] p;
    int          lat, preq;

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        n_cmp++;
        if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0 || bus.ptw_req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctl: req_ready=%b resp_valid=%b ptw_req_valid=%b, required 1 0 0",
                     bus.req_ready, bus.resp_valid, bus.ptw_req_valid);
        end
        n_cmp++;
        if (bus.resp_hit !== 1'b0 || bus.resp_error !== 1'b0 || bus.resp_ppn !== 32'h0 ||
            bus.ptw_req_vpn !== 20'h0) begin
            n_fail++;
            $display("FAIL reset_data: hit=%b err=%b ppn=%h ptw_vpn=%h, required all zero",
                     bus.resp_hit, bus.resp_error, bus.resp_ppn, bus.ptw_req_vpn);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        run_req(20'h00012, 32'hABCD0000, 1'b0, 0, 2, -1, h, e, p, lat, preq, vok, tmo);
        n_cmp++;
        if (tmo || h !== 1'b0 || e !== 1'b0 || p !== 32'hABCD0000 || vok !== 1'b1 || preq !== 1) begin
            n_fail++;
            $display("FAIL basic_miss: tmo=%b hit=%b err=%b ppn=%h vok=%b preq=%0d, required 0 0 0 abcd0000 1 1",
                     tmo, h, e, p, vok, preq);
        end
        model_fill(20'h00012, 32'hABCD0000);
        run_req(20'h00012, 32'h0, 1'b0, 0, 0, -1, h, e, p, lat, preq, vok, tmo);
        n_cmp++;
        if (tmo || h !== 1'b1 || lat !== 1 || p !== 32'hABCD0000 || preq !== 0) begin
            n_fail++;
            $display("FAIL basic_hit: tmo=%b hit=%b lat=%0d ppn=%h preq=%0d, required 0 1 1 abcd0000 0",
                     tmo, h, lat, p, preq);
        end
    endtask

    task automatic test_replace();
        do_reset();
        for (int i = 1; i <= 9; i++) begin
            run_req(20'(i), 32'h1000 + 32'(i), 1'b0, 0, 1, -1, h, e, p, lat, preq, vok, tmo);
            n_cmp++;
            if (tmo || h !== 1'b0 || p !== 32'h1000 + 32'(i)) begin
                n_fail++;
                $display("FAIL replace_fill%0d: tmo=%b hit=%b ppn=%h, required 0 0 %h",
                         i, tmo, h, p, 32'h1000 + 32'(i));
            end
            model_fill(20'(i), 32'h1000 + 32'(i));
        end
        run_req(20'h2, 32'h0, 1'b0, 0, 0, -1, h, e, p, lat, preq, vok, tmo);
        n_cmp++;
        if (tmo || h !== 1'b1 || p !== 32'h1002 || lat !== 1) begin
            n_fail++;
            $display("FAIL replace_hit2: tmo=%b hit=%b ppn=%h lat=%0d, required 0 1 00001002 1", tmo, h, p, lat);
        end
        run_req(20'h1, 32'hBEEF, 1'b0, 0, 0, -1, h, e, p, lat, preq, vok, tmo);
        n_cmp++;
        if (tmo || h !== 1'b0 || p !== 32'hBEEF) begin
            n_fail++;
            $display("FAIL replace_miss1: tmo=%b hit=%b ppn=%h, required 0 0 0000beef", tmo, h, p);
        end
        model_fill(20'h1, 32'hBEEF);
    endtask

    task automatic test_error();
        for (int k = 0; k < 2; k++) begin
            run_req(20'h20, 32'h5555, 1'b1, 0, 1, -1, h, e, p, lat, preq, vok, tmo);
            n_cmp++;
            if (tmo || h !== 1'b0 || e !== 1'b1 || p !== 32'h0 || preq !== 1) begin
                n_fail++;
                $display("FAIL error_%0d: tmo=%b hit=%b err=%b ppn=%h preq=%0d, required 0 0 1 0 1",
                         k, tmo, h, e, p, preq);
            end
        end
    endtask

    task automatic test_stall();
        run_req(20'h70, 32'h7070, 1'b0, 5, 1, -1, h, e, p, lat, preq, vok, tmo);
        n_cmp++;
        if (tmo || preq !== 6 || vok !== 1'b1 || h !== 1'b0 || p !== 32'h7070) begin
            n_fail++;
            $display("FAIL stall: tmo=%b preq=%0d vok=%b hit=%b ppn=%h, required 0 6 1 0 00007070",
                     tmo, preq, vok, h, p);
        end
        model_fill(20'h70, 32'h7070);
    endtask

    task automatic test_flush_wait();
        do_reset();
        run_req(20'h30, 32'h3000, 1'b0, 0, 0, -1, h, e, p, lat, preq, vok, tmo);
        model_fill(20'h30, 32'h3000);
        run_req(20'h40, 32'h77, 1'b0, 0, 4, 1, h, e, p, lat, preq, vok, tmo);
        n_cmp++;
        if (tmo || h !== 1'b0 || e !== 1'b0 || p !== 32'h77) begin
            n_fail++;
            $display("FAIL flush_resp: tmo=%b hit=%b err=%b ppn=%h, required 0 0 0 00000077", tmo, h, e, p);
        end
        model_clear();
        run_req(20'h40, 32'h78, 1'b0, 0, 0, -1, h, e, p, lat, preq, vok, tmo);
        n_cmp++;
        if (tmo || h !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_refetch: tmo=%b hit=%b, required 0 0", tmo, h);
        end
        model_fill(20'h40, 32'h78);
        run_req(20'h30, 32'h31, 1'b0, 0, 0, -1, h, e, p, lat, preq, vok, tmo);
        n_cmp++;
        if (tmo || h !== 1'b0 || p !== 32'h31) begin
            n_fail++;
            $display("FAIL flush_old: tmo=%b hit=%b ppn=%h, required 0 0 00000031", tmo, h, p);
        end
        model_fill(20'h30, 32'h31);
    endtask

    task automatic test_reset_wait();
        do_reset();
        run_req(20'h50, 32'h5050, 1'b0, 0, 0, -1, h, e, p, lat, preq, vok, tmo);
        bus.req_vpn = 20'h60; bus.req_valid = 1'b1; bus.ptw_req_ready = 1'b1;
        @(posedge clk); #1; bus.req_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.ptw_req_ready = 1'b0; reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; bus.ptw_resp_valid = 1'b1; bus.ptw_resp_ppn = 32'h6060; bus.ptw_resp_error = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_wait: resp_valid=%b req_ready=%b, required 0 1", bus.resp_valid, bus.req_ready);
        end
        @(posedge clk); #1; bus.ptw_resp_valid = 1'b0;
        model_clear();
        run_req(20'h50, 32'h5151, 1'b0, 0, 0, -1, h, e, p, lat, preq, vok, tmo);
        n_cmp++;
        if (tmo || h !== 1'b0 || p !== 32'h5151) begin
            n_fail++;
            $display("FAIL reset_wait_miss: tmo=%b hit=%b ppn=%h, required 0 0 00005151", tmo, h, p);
        end
        model_fill(20'h50, 32'h5151);
    endtask

    task automatic test_random();
        logic [19:0] v;
        logic [31:0] rp;
        logic        re;
        int          rd, sd, fa, idx;
        do_reset();
        for (int t = 0; t < 60; t++) begin
            v  = 20'h100 + 20'($urandom_range(0, 11));
            rp = $urandom;
            re = ($urandom_range(0, 5) == 0);
            rd = $urandom_range(0, 3);
            sd = $urandom_range(0, 3);
            fa = ($urandom_range(0, 6) == 0) ? $urandom_range(0, sd) : -1;
            idx = model_find(v);
            run_req(v, rp, re, rd, sd, fa, h, e, p, lat, preq, vok, tmo);
            n_cmp++;
            if (idx >= 0) begin
                if (tmo || h !== 1'b1 || e !== 1'b0 || p !== m_ppn[idx] || lat !== 1 || preq !== 0) begin
                    n_fail++;
                    $display("FAIL rand_hit t=%0d vpn=%h: tmo=%b hit=%b err=%b ppn=%h lat=%0d, required 0 1 0 %h 1",
                             t, v, tmo, h, e, p, lat, m_ppn[idx]);
                end
            end else begin
                if (tmo || h !== 1'b0 || e !== re || p !== (re ? 32'h0 : rp) || vok !== 1'b1 || preq !== rd + 1) begin
                    n_fail++;
                    $display("FAIL rand_miss t=%0d vpn=%h: tmo=%b hit=%b err=%b ppn=%h preq=%0d, required 0 0 %b %h %0d",
                             t, v, tmo, h, e, p, preq, re, (re ? 32'h0 : rp), rd + 1);
                end
                if (fa >= 0) model_clear();
                else if (!re) model_fill(v, rp);
            end
        end
    endtask

    initial begin
        n_cmp = 0; n_fail = 0;
        reset = 1'b1;
        test_reset();
        test_basic();
        test_replace();
        test_error();
        test_stall();
        test_flush_wait();
        test_reset_wait();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
